xgmii_link_ctrl_mc: RTL
=======================

Name: xgmii_link_ctrl_mc

Overview:
Multi-channel successor to the single-port 10G MAC/PHY glue. Per channel it provides:
- input synchronisation of PHY status;
- a debounced link-up state machine driving the MAC core reset;
- a configurable-depth XGMII TX/RX register pipeline;
- a saturating link-drop counter.

It sits between NUM_CH 10G MAC cores and their XPHY instances. The whole block runs on the shared 156.25 MHz core clock.

Parameters:
NUM_CH, 2, number of MAC/PHY channels (1..8)
PIPE_STAGES, 1, XGMII register stages per direction (1..4)
DEBOUNCE_CYCLES, 1024, consecutive good-status cycles required before link up (>=2)
CNT_W, 16, width of each link-drop counter
C_MDIO_ADDR_BASE, 5'h0, MDIO port address of channel 0; channel i gets base+i (mod 32)

Ports:
clk156  in  1  156.25 MHz core clock
reset  in  1  asynchronous, active-high reset
tx_resetdone  in  NUM_CH  per-channel GT TX reset done (async)
rx_resetdone  in  NUM_CH  per-channel GT RX reset done (async)
tx_fault  in  NUM_CH  SFP TX fault (async)
signal_detect  in  NUM_CH  SFP signal detect (async)
link_cnt_clr  in  1  pulse: clear all link-drop counters
xgmii_txd  in  NUM_CH*64  MAC TX data, channel i at [64i+63:64i]
xgmii_txc  in  NUM_CH*8  MAC TX control
xgmii_rxd_int  in  NUM_CH*64  PHY RX data
xgmii_rxc_int  in  NUM_CH*8  PHY RX control
xgmii_txd_int  out  NUM_CH*64  TX data to PHY
xgmii_txc_int  out  NUM_CH*8  TX control to PHY
xgmii_rxd  out  NUM_CH*64  RX data to MAC
xgmii_rxc  out  NUM_CH*8  RX control to MAC
core_reset  out  NUM_CH  per-channel MAC reset (tx_reset/rx_reset source)
link_state  out  NUM_CH*2  per-channel FSM state code
link_up  out  NUM_CH  1 when channel in UP
link_drop_cnt  out  NUM_CH*CNT_W  per-channel link-drop count
resetdone  out  1  AND of all synchronised tx/rx resetdone
prtad  out  NUM_CH*5  per-channel MDIO address

Behaviour:
- Synchronisation:
  - Each async status input passes through a 2-flop synchroniser (async_reg); flops preset to the "bad" value on reset.
  - ok_s[i] = tx_done_s & rx_done_s & !fault_s & sd_s.
- FSM, per channel; codes RST=0, WAIT=1, DEBOUNCE=2, UP=3:
  - Reset forces RST.
  - RST -> WAIT at first edge after reset release.
  - WAIT -> DEBOUNCE when ok_s; debounce counter loads 0.
  - DEBOUNCE, ok_s: counter increments; at count==DEBOUNCE_CYCLES-1 with ok_s -> UP.
  - DEBOUNCE, !ok_s -> WAIT, no counter bump.
  - UP, !ok_s -> WAIT, and link_drop_cnt[i] increments.
- Latency: with raw inputs good before edge e0, core_reset[i] deasserts after edge e(DEBOUNCE_CYCLES+2). A status loss before e0 gives core_reset high after e2.
- Outputs decoded from the state register, no extra delay:
  - core_reset[i] = (state != UP);
  - link_up[i] = (state == UP);
  - link_state = state code.
- Reset values:
  - core_reset all 1s; link_up 0; link_state 0; link_drop_cnt 0; resetdone 0.
  - XGMII data registers are not reset; contents are undefined until PIPE_STAGES edges after valid input.
- link_drop_cnt:
  - saturates at all-ones;
  - link_cnt_clr zeroes all counters the next edge;
  - clear and increment on the same edge -> 0.
- XGMII pipeline: TX and RX each delayed exactly PIPE_STAGES clk156 edges; no per-channel interaction.
- resetdone: registered AND of all synchronised resetdone bits.
- prtad: constant, C_MDIO_ADDR_BASE+i truncated to 5 bits.
- Channels are fully independent; reset mid-operation returns every channel to RST in the same cycle (asynchronous).

Optional Feature:
Macro XGMII_IDLE_INSERT_EN.
- Defined: while core_reset[i]=1, the final TX stage for channel i loads idle: txd=64'h0707070707070707, txc=8'hFF. Normal data resumes on the first edge with core_reset[i]=0, with the PIPE_STAGES latency applied to the new data. RX is unaffected.
- Not defined: TX is a pure delay of xgmii_txd/txc regardless of link state.

Test Plan:
1. NUM_CH=2, DEBOUNCE_CYCLES=16. Assert reset, release, then drive all inputs good on ch0 -> core_reset[0] falls after edge 18, link_state[1:0]=3; ch1 (signal_detect=0) stays link_state=1, core_reset[1]=1.
2. ch0 in DEBOUNCE: drop signal_detect for 1 cycle at debounce count 10 -> returns to WAIT, link_drop_cnt unchanged, UP reached only after a further full 16-cycle window.
3. ch0 in UP: pulse tx_fault 3 times -> link_drop_cnt[0]=3. Set CNT_W=2 with 5 drops -> stays 3. link_cnt_clr coincident with a drop -> 0.
4. PIPE_STAGES=3: drive txd=64'hDEADBEEF_00000001 on cycle n with channel UP -> appears on xgmii_txd_int at n+3; RX likewise.
5. XGMII_IDLE_INSERT_EN defined, ch1 in WAIT, txd=64'h1234 -> xgmii_txd_int[127:64]=64'h0707070707070707, txc=8'hFF. Undefined -> 64'h1234 passes through.
6. Assert reset asynchronously while both channels are UP -> core_reset=2'b11 and link_up=0 immediately, counters 0, resetdone 0; C_MDIO_ADDR_BASE=5'h1F gives prtad = {5'h00,5'h1F}.

Source files
------------

// File: rtl/xgmii_link_ctrl_mc.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// xgmii_link_ctrl_mc
//
// Multi-channel glue between NUM_CH 10G MAC cores and their XPHY instances,
// all running on the shared 156.25 MHz core clock. Per channel:
//   - 2-flop synchronisers on the asynchronous PHY/SFP status inputs
//   - debounced link FSM (RST -> WAIT -> DEBOUNCE -> UP) driving the MAC reset
//   - PIPE_STAGES-deep XGMII TX and RX register pipelines
//   - saturating link-drop counter
//
// Optional feature, macro XGMII_IDLE_INSERT_EN:
//   defined   - while a channel's core_reset is high, the last TX stage of that
//               channel loads XGMII idle (txd 0707..07, txc FF)
//   undefined - TX is a pure PIPE_STAGES delay
//
// Ports:
//   clk156            core clock
//   reset             asynchronous, active-high reset
//   tx_resetdone      per-channel GT TX reset done (async)
//   rx_resetdone      per-channel GT RX reset done (async)
//   tx_fault          per-channel SFP TX fault (async)
//   signal_detect     per-channel SFP signal detect (async)
//   link_cnt_clr      pulse, clears every link-drop counter
//   xgmii_txd/txc     MAC TX data/control, channel i at [64i+63:64i] / [8i+7:8i]
//   xgmii_rxd_int/rxc_int  PHY RX data/control
//   xgmii_txd_int/txc_int  TX data/control to PHY
//   xgmii_rxd/rxc     RX data/control to MAC
//   core_reset        per-channel MAC reset, high unless channel is UP
//   link_state        per-channel 2-bit FSM state code
//   link_up           per-channel, high in UP
//   link_drop_cnt     per-channel CNT_W-bit link-drop count
//   resetdone         registered AND of all synchronised tx/rx resetdone bits
//   prtad             per-channel MDIO port address (base + i, mod 32)
// -----------------------------------------------------------------------------
module xgmii_link_ctrl_mc #(
   parameter int         NUM_CH           = 2,
   parameter int         PIPE_STAGES      = 1,
   parameter int         DEBOUNCE_CYCLES  = 1024,
   parameter int         CNT_W            = 16,
   parameter logic [4:0] C_MDIO_ADDR_BASE = 5'h0
) (
   input  logic                    clk156,
   input  logic                    reset,
   input  logic [NUM_CH-1:0]       tx_resetdone,
   input  logic [NUM_CH-1:0]       rx_resetdone,
   input  logic [NUM_CH-1:0]       tx_fault,
   input  logic [NUM_CH-1:0]       signal_detect,
   input  logic                    link_cnt_clr,
   input  logic [NUM_CH*64-1:0]    xgmii_txd,
   input  logic [NUM_CH*8-1:0]     xgmii_txc,
   input  logic [NUM_CH*64-1:0]    xgmii_rxd_int,
   input  logic [NUM_CH*8-1:0]     xgmii_rxc_int,
   output logic [NUM_CH*64-1:0]    xgmii_txd_int,
   output logic [NUM_CH*8-1:0]     xgmii_txc_int,
   output logic [NUM_CH*64-1:0]    xgmii_rxd,
   output logic [NUM_CH*8-1:0]     xgmii_rxc,
   output logic [NUM_CH-1:0]       core_reset,
   output logic [NUM_CH*2-1:0]     link_state,
   output logic [NUM_CH-1:0]       link_up,
   output logic [NUM_CH*CNT_W-1:0] link_drop_cnt,
   output logic                    resetdone,
   output logic [NUM_CH*5-1:0]     prtad
);

   localparam int              DBC_W    = $clog2(DEBOUNCE_CYCLES);
   localparam logic [DBC_W-1:0] DBC_LAST = DBC_W'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_RST  = 2'd0,
      ST_WAIT = 2'd1,
      ST_DEB  = 2'd2,
      ST_UP   = 2'd3
   } state_t;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   // ---- status synchronisers; reset parks every flop at its "bad" level ----
   (* ASYNC_REG = "TRUE" *) logic [NUM_CH-1:0] txdone_m_q, txdone_s_q;
   (* ASYNC_REG = "TRUE" *) logic [NUM_CH-1:0] rxdone_m_q, rxdone_s_q;
   (* ASYNC_REG = "TRUE" *) logic [NUM_CH-1:0] fault_m_q,  fault_s_q;
   (* ASYNC_REG = "TRUE" *) logic [NUM_CH-1:0] sd_m_q,     sd_s_q;
   logic [NUM_CH-1:0] ok_s;
   logic              resetdone_q;

   always_ff @(posedge clk156 or posedge reset) begin
      if (reset) begin
         txdone_m_q  <= '0;
         txdone_s_q  <= '0;
         rxdone_m_q  <= '0;
         rxdone_s_q  <= '0;
         fault_m_q   <= '1;
         fault_s_q   <= '1;
         sd_m_q      <= '0;
         sd_s_q      <= '0;
         resetdone_q <= 1'b0;
      end else begin
         txdone_m_q  <= tx_resetdone;
         txdone_s_q  <= txdone_m_q;
         rxdone_m_q  <= rx_resetdone;
         rxdone_s_q  <= rxdone_m_q;
         fault_m_q   <= tx_fault;
         fault_s_q   <= fault_m_q;
         sd_m_q      <= signal_detect;
         sd_s_q      <= sd_m_q;
         resetdone_q <= &{txdone_s_q, rxdone_s_q};
      end
   end

   assign ok_s      = txdone_s_q & rxdone_s_q & ~fault_s_q & sd_s_q;
   assign resetdone = resetdone_q;

   // ---- per-channel link FSM and drop counter ----
   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      state_t           state_q, state_d;
      logic [DBC_W-1:0] dbc_q, dbc_d;
      logic [CNT_W-1:0] drop_q, drop_d;
      logic             drop_inc;

      always_comb begin
         state_d  = state_q;
         dbc_d    = dbc_q;
         drop_inc = 1'b0;
         case (state_q)
            ST_RST:  state_d = ST_WAIT;
            ST_WAIT: begin
               if (ok_s[i]) begin
                  state_d = ST_DEB;
                  dbc_d   = '0;
               end
            end
            ST_DEB: begin
               // A single bad cycle abandons the window without touching the count.
               if (!ok_s[i]) begin
                  state_d = ST_WAIT;
               end else if (dbc_q == DBC_LAST) begin
                  state_d = ST_UP;
               end else begin
                  dbc_d = dbc_q + 1'b1;
               end
            end
            ST_UP: begin
               if (!ok_s[i]) begin
                  state_d  = ST_WAIT;
                  drop_inc = 1'b1;
               end
            end
            default: state_d = ST_RST;
         endcase

         // Clear wins over a coincident increment.
         drop_d = drop_q;
         if (link_cnt_clr) begin
            drop_d = '0;
         end else if (drop_inc) begin
            drop_d = sat_inc(drop_q);
         end
      end

      always_ff @(posedge clk156 or posedge reset) begin
         if (reset) begin
            state_q <= ST_RST;
            dbc_q   <= '0;
            drop_q  <= '0;
         end else begin
            state_q <= state_d;
            dbc_q   <= dbc_d;
            drop_q  <= drop_d;
         end
      end

      assign core_reset[i]                    = (state_q != ST_UP);
      assign link_up[i]                       = (state_q == ST_UP);
      assign link_state[2*i +: 2]             = state_q;
      assign link_drop_cnt[CNT_W*i +: CNT_W]  = drop_q;
      assign prtad[5*i +: 5]                  = C_MDIO_ADDR_BASE + 5'(i);
   end

   // ---- XGMII pipelines (data path, never reset) ----
   logic [PIPE_STAGES-1:0][NUM_CH*64-1:0] txd_p, txd_n, rxd_p, rxd_n;
   logic [PIPE_STAGES-1:0][NUM_CH*8-1:0]  txc_p, txc_n, rxc_p, rxc_n;

   always_comb begin
      txd_n[0] = xgmii_txd;
      txc_n[0] = xgmii_txc;
      rxd_n[0] = xgmii_rxd_int;
      rxc_n[0] = xgmii_rxc_int;
      for (int s = 1; s < PIPE_STAGES; s++) begin
         txd_n[s] = txd_p[s-1];
         txc_n[s] = txc_p[s-1];
         rxd_n[s] = rxd_p[s-1];
         rxc_n[s] = rxc_p[s-1];
      end
`ifdef XGMII_IDLE_INSERT_EN
      // Only the last TX stage is overridden, so data already in flight when
      // the link comes up still sees the full pipeline latency.
      for (int c = 0; c < NUM_CH; c++) begin
         if (core_reset[c]) begin
            txd_n[PIPE_STAGES-1][64*c +: 64] = 64'h0707070707070707;
            txc_n[PIPE_STAGES-1][8*c +: 8]   = 8'hFF;
         end
      end
`endif
   end

   always_ff @(posedge clk156) begin
      txd_p <= txd_n;
      txc_p <= txc_n;
      rxd_p <= rxd_n;
      rxc_p <= rxc_n;
   end

   assign xgmii_txd_int = txd_p[PIPE_STAGES-1];
   assign xgmii_txc_int = txc_p[PIPE_STAGES-1];
   assign xgmii_rxd     = rxd_p[PIPE_STAGES-1];
   assign xgmii_rxc     = rxc_p[PIPE_STAGES-1];

endmodule
